// File: rtl/line_pixel_writer.sv
// Pixel-stream sink: buffers (x,y,color) points and issues one single-beat framebuffer write per point.
// Define LINE_WR_CLIP_EN to retire off-screen points without a write and count them in drop_count.
`timescale 1ns/1ps
module line_pixel_writer #(
  parameter int H_RES      = 800,
  parameter int V_RES      = 480,
  parameter int COLOR_W    = 24,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [10:0]        in_x,
  input  logic [9:0]         in_y,
  input  logic [COLOR_W-1:0] in_color,
  input  logic               in_last,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  output logic               mem_write,
  input  logic               mem_waitrequest,
  output logic               busy,
  output logic               done,
  output logic [15:0]        pix_count,
  output logic [15:0]        drop_count
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  generate
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("line_pixel_writer: FIFO_DEPTH must be a power of two >= 2");
    end
    if (ADDR_W < $clog2(H_RES * V_RES)) begin : g_bad_addr_w
      $error("line_pixel_writer: ADDR_W too narrow for H_RES*V_RES");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DROP} state_e;

  logic [10:0]        x_mem    [FIFO_DEPTH];
  logic [9:0]         y_mem    [FIFO_DEPTH];
  logic [COLOR_W-1:0] c_mem    [FIFO_DEPTH];
  logic               last_mem [FIFO_DEPTH];
  logic               drop_mem [FIFO_DEPTH];

  logic [PTR_W-1:0]   wr_q, rd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ready_q;
  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [COLOR_W-1:0] wdata_q;
  logic               last_q;
  logic               done_q;
  logic [15:0]        pix_q;

  logic push, pop, retire, empty, drop_in;

`ifdef LINE_WR_CLIP_EN
  assign drop_in = (int'(in_x) >= H_RES) || (int'(in_y) >= V_RES);
`else
  assign drop_in = 1'b0;
`endif

  // ready_q keeps in_ready low while reset is held and for the release edge
  assign in_ready = ready_q && (cnt_q != CNT_W'(FIFO_DEPTH));
  assign push     = in_valid && in_ready;
  assign empty    = (cnt_q == '0);
  // product taken modulo 2^ADDR_W, equal to truncating the full-width product
  assign addr_d   = ADDR_W'(y_mem[rd_q]) * ADDR_W'(H_RES) + ADDR_W'(x_mem[rd_q]);

  always_ff @(posedge clk) begin
    if (push) begin
      x_mem[wr_q]    <= in_x;
      y_mem[wr_q]    <= in_y;
      c_mem[wr_q]    <= in_color;
      last_mem[wr_q] <= in_last;
      drop_mem[wr_q] <= drop_in;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    retire  = 1'b0;
    unique case (state_q)
      S_IDLE:  pop = !empty;
      S_WRITE: begin
        if (!mem_waitrequest) begin
          retire = 1'b1;
          pop    = !empty;
        end
      end
      S_DROP: begin
        retire = 1'b1;
        pop    = !empty;
      end
      default: ;
    endcase
    if (pop) begin
      state_d = drop_mem[rd_q] ? S_DROP : S_WRITE;
    end else if (retire) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
      if (push) begin
        wr_q <= wr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_q    <= rd_q + PTR_W'(1);
        addr_q  <= addr_d;
        wdata_q <= c_mem[rd_q];
        last_q  <= last_mem[rd_q];
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
      done_q <= retire && last_q;
      if (retire && (state_q == S_WRITE) && (pix_q != '1)) begin
        pix_q <= pix_q + 16'd1;
      end
    end
  end

`ifdef LINE_WR_CLIP_EN
  logic [15:0] drop_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
    end else if (retire && (state_q == S_DROP) && (drop_q != '1)) begin
      drop_q <= drop_q + 16'd1;
    end
  end
  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif

  assign mem_write = (state_q == S_WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = !empty || mem_write;
  assign done      = done_q;
  assign pix_count = pix_q;

endmodule

// File: tb/tb_line_pixel_writer.sv
// Self-checking bench for line_pixel_writer: directed cases plus random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_line_pixel_writer;
  localparam int H_RES   = 800;
  localparam int V_RES   = 480;
  localparam int COLOR_W = 24;
  localparam int ADDR_W  = 19;
  localparam int DEPTH   = 8;
`ifdef LINE_WR_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [10:0]        in_x = '0;
  logic [9:0]         in_y = '0;
  logic [COLOR_W-1:0] in_color = '0;
  logic               in_last = 1'b0;
  logic [ADDR_W-1:0]  mem_addr;
  logic [COLOR_W-1:0] mem_wdata;
  logic               mem_write;
  logic               mem_waitrequest = 1'b0;
  logic               busy, done;
  logic [15:0]        pix_count, drop_count;

  line_pixel_writer #(.H_RES(H_RES), .V_RES(V_RES), .COLOR_W(COLOR_W),
                      .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_color(in_color), .in_last(in_last),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_waitrequest(mem_waitrequest), .busy(busy), .done(done),
    .pix_count(pix_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: every accepted point, in order, with its expected address and fate
  typedef struct {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] data;
    bit                 drop;
  } pt_t;
  pt_t q[$];
  int exp_pix = 0, exp_drop = 0, exp_done = 0, done_seen = 0;
  int accepts = 0, wr_done = 0, cyc = 0, first_wr = -1, last_wr = -1;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (in_valid && in_ready) begin
        pt_t p;
        p.addr = ADDR_W'((int'(in_y) * H_RES + int'(in_x)) % (1 << ADDR_W));
        p.data = in_color;
        p.drop = CLIP && ((int'(in_x) >= H_RES) || (int'(in_y) >= V_RES));
        q.push_back(p);
        accepts++;
        if (p.drop) exp_drop = (exp_drop < 65535) ? exp_drop + 1 : 65535;
        else        exp_pix  = (exp_pix  < 65535) ? exp_pix  + 1 : 65535;
        if (in_last) exp_done++;
      end
      if (done) done_seen++;
      if (mem_write) begin
        while (q.size() > 0 && q[0].drop) void'(q.pop_front());
        check_eq("wr_pending", 64'(q.size() > 0), 64'd1);
        if (q.size() > 0) begin
          check_eq("wr_addr", 64'(mem_addr), 64'(q[0].addr));
          check_eq("wr_data", 64'(mem_wdata), 64'(q[0].data));
          if (!mem_waitrequest) begin
            void'(q.pop_front());
            wr_done++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pt(input int x, input int y, input logic [COLOR_W-1:0] c, input bit last);
    in_valid = 1'b1;
    in_x     = 11'(x);
    in_y     = 10'(y);
    in_color = c;
    in_last  = last;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    mem_waitrequest = 1'b0;
    while (busy && n < 500) begin
      tick();
      n++;
    end
    repeat (3) tick();
    while (q.size() > 0 && q[0].drop) void'(q.pop_front());
    check_eq("drain_timeout", 64'(n < 500), 64'd1);
    check_eq("drain_queue", 64'(q.size()), 64'd0);
    check_eq("pix_count", 64'(pix_count), 64'(exp_pix));
    check_eq("drop_count", 64'(drop_count), 64'(exp_drop));
    check_eq("done_pulses", 64'(done_seen), 64'(exp_done));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, low, dbase;

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    check_eq("rst_mem_write", 64'(mem_write), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_pix", 64'(pix_count), 64'd0);
    check_eq("rst_drop", 64'(drop_count), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b0;
    tick();
    check_eq("rel_in_ready", 64'(in_ready), 64'd1);

    // Single point: accept edge, pop edge, retire edge
    set_pt(10, 2, 24'hFF0000, 1'b1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_eq("lat_n1_write", 64'(mem_write), 64'd0);
    tick();
    check_eq("lat_n2_write", 64'(mem_write), 64'd1);
    check_eq("single_addr", 64'(mem_addr), 64'd1610);
    check_eq("single_data", 64'(mem_wdata), 64'hFF0000);
    check_eq("single_done_early", 64'(done), 64'd0);
    tick();
    check_eq("single_write_len", 64'(mem_write), 64'd0);
    check_eq("single_done", 64'(done), 64'd1);
    check_eq("single_pix", 64'(pix_count), 64'd1);
    tick();
    check_eq("single_done_pulse", 64'(done), 64'd0);

    // Burst of 20 with no stall: one write per clock, never back-pressured
    first_wr = -1;
    base = wr_done;
    low = 0;
    for (int i = 0; i < 20; i++) begin
      set_pt($urandom_range(0, H_RES - 1), $urandom_range(0, V_RES - 1), COLOR_W'($urandom), i == 19);
      if (!in_ready) low++;
      tick();
    end
    drain();
    check_eq("burst_ready_low", 64'(low), 64'd0);
    check_eq("burst_writes", 64'(wr_done - base), 64'd20);
    check_eq("burst_contig", 64'(last_wr - first_wr + 1), 64'd20);

    // Long stall: FIFO plus output register fill, then back-pressure
    mem_waitrequest = 1'b1;
    base = accepts;
    for (int i = 0; i < 30; i++) begin
      set_pt($urandom_range(0, H_RES - 1), $urandom_range(0, V_RES - 1), COLOR_W'($urandom), 1'b0);
      tick();
    end
    check_eq("stall_accepts", 64'(accepts - base), 64'(DEPTH + 1));
    check_eq("stall_ready", 64'(in_ready), 64'd0);
    check_eq("stall_write", 64'(mem_write), 64'd1);
    drain();

    // Reset with points buffered and a write outstanding
    mem_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_pt($urandom_range(0, H_RES - 1), $urandom_range(0, V_RES - 1), COLOR_W'($urandom), 1'b1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check_eq("mid_rst_write", 64'(mem_write), 64'd0);
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_pix", 64'(pix_count), 64'd0);
    q.delete();
    exp_pix = 0; exp_drop = 0; exp_done = 0; done_seen = 0;
    reset = 1'b0;
    mem_waitrequest = 1'b0;
    base = wr_done;
    repeat (10) tick();
    check_eq("post_rst_writes", 64'(wr_done - base), 64'd0);
    check_eq("post_rst_pix", 64'(pix_count), 64'd0);

    // Clipping corner points
    base  = wr_done;
    dbase = done_seen;
    set_pt(799, 479, 24'h00A5A5, 1'b0); tick();
    set_pt(800, 0,   24'h111111, 1'b0); tick();
    set_pt(0,   480, 24'h222222, 1'b1); tick();
    drain();
    check_eq("clip_writes", 64'(wr_done - base), CLIP ? 64'd1 : 64'd3);
    check_eq("clip_drop_count", 64'(drop_count), CLIP ? 64'd2 : 64'd0);
    check_eq("clip_done_once", 64'(done_seen - dbase), 64'd1);

    // Random traffic with random stalls and occasional off-screen points
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        set_pt(($urandom_range(0, 7) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, H_RES - 1),
               ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, V_RES - 1),
               COLOR_W'($urandom), $urandom_range(0, 4) == 0);
      end else begin
        in_valid = 1'b0;
      end
      mem_waitrequest = ($urandom_range(0, 2) == 0);
      tick();
    end
    drain();

    // Saturation of pix_count
    for (int i = 0; i < 65540; i++) begin
      set_pt($urandom_range(0, H_RES - 1), $urandom_range(0, V_RES - 1), COLOR_W'($urandom), 1'b0);
      tick();
    end
    drain();
    check_eq("pix_saturated", 64'(pix_count), 64'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
